branch_pc_unit: RTL
===================

# branch_pc_unit

Program-counter owner and branch resolver for the single-issue datapath. It is the driving end of the 2:1 next-PC select mux. It supplies the mux's two data inputs (`pcPlus4` and `branchTarget`) and its `selectBranch` line, and it registers the mux result (`nextPc`) as the new PC. It also generates the pipeline flush window after a taken branch and counts taken branches for debug.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value after reset.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high after a taken branch. Legal range 1..15.

- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: holds the PC and freezes the FSM/counter. The branch is not resolved while this is high.
- `brValid`  in  1: a branch or jump instruction is in the resolve stage.
- `brType`  in  2: 00 beq, 01 bne, 10 j, 11 jr.
- `brPc`  in  32: PC of the branch instruction.
- `rsData`  in  32: first operand; also the jr target.
- `rtData`  in  32: second operand.
- `imm`  in  32: sign-extended word offset (beq/bne).
- `jAddr`  in  26: jump index (j).
- `nextPc`  in  32: mux result, fed back from the select mux.
- `pc`  out  32: current PC (registered).
- `pcPlus4`  out  32: `pc + 4`, drives mux DataA.
- `branchTarget`  out  32: resolved target, drives mux DataB.
- `selectBranch`  out  1: mux select. 1 picks `branchTarget`.
- `flush`  out  1: kill wrong-path instructions in the fetch and decode stages.
- `branchCount`  out  32: number of taken branches since reset.

## Operation
- Arithmetic is modulo 2^32 throughout. Carries out of bit 31 are dropped.
- Target computation:
  - beq/bne: `brPc + 4 + (imm << 2)`.
  - j: `{(brPc+4)[31:28], jAddr, 2'b00}`.
  - jr: `{rsData[31:2], 2'b00}`. The low bits are always cleared.
- `branchTarget` is computed combinationally from the current inputs every cycle, whether or not `brValid` is high.
- Taken condition:
  - beq: `rsData == rtData`.
  - bne: `rsData != rtData`.
  - j and jr: always taken.
- Resolve condition: `resolve = brValid & !stall & state==RUN`.
- `selectBranch = resolve & taken`. It is combinational and forced to 0 while `rst_n` is low.
- PC register: on each edge with `!stall`, `pc <= nextPc`. With `stall` high, `pc` holds.
- FSM with two states, RUN and FLUSH:
  - RUN → FLUSH on the edge where `selectBranch` is 1. The counter loads `FLUSH_CYCLES-1` and `branchCount` increments.
  - FLUSH: `brValid` is ignored, so `selectBranch` is 0 and the PC advances by 4. The counter decrements on each non-stalled edge.
  - FLUSH → RUN on the non-stalled edge where the counter is 0.
  - With `stall` high in FLUSH, the counter and state hold and `flush` stays high.
- `flush` is registered and equals `state==FLUSH`.
- `branchCount` wraps from 32'hFFFF_FFFF to 0.
- A not-taken beq/bne causes no state change and no flush.

## Timing
- Reset values:
  - `pc` = `PC_RESET`.
  - `pcPlus4` = `PC_RESET + 4`.
  - `flush` = 0, `branchCount` = 0, state = RUN, counter = 0.
  - `selectBranch` = 0.
- Reset asserted mid-FLUSH returns the block to RUN immediately, without waiting for a clock edge.
- Taken-branch latency:
  - Resolved in cycle N (combinational select).
  - `pc == branchTarget` after edge N+1.
  - `flush` high for exactly `FLUSH_CYCLES` non-stalled cycles starting at cycle N+1.
- Back-to-back branches: a branch presented during FLUSH is not resolved and not counted. The upstream stages drop it under `flush`.
- `stall` and `brValid` both high: nothing is resolved. The upstream holds the branch, and it resolves on the first non-stalled cycle. It is counted exactly once.

## Test plan
- Reset release with `PC_RESET`=0 and no branches for 4 cycles → `pc` steps 0, 4, 8, 12; `flush`=0; `selectBranch`=0.
- beq at `brPc`=0x100 with `rsData`=`rtData`=5 and `imm`=3 → `selectBranch`=1 and `branchTarget`=0x110 in the same cycle. After the next edge, `pc`=0x110 and `flush`=1 for 2 cycles. `branchCount`=1.
- bne with `rsData`=`rtData` → `selectBranch`=0, `pc` advances by 4, `flush` stays 0, `branchCount` unchanged.
- jr with `rsData`=0x0000_2003 and `stall` high for 3 cycles, then low → no change while stalled. It then resolves once: `pc`=0x2000, `branchCount` +1.
- j taken, then a second `brValid` (beq taken) in the first flush cycle → the second branch is ignored, `branchCount`=1, and `flush` lasts 2 cycles. `rst_n` pulsed low in the second flush cycle → `flush`=0 and `pc`=`PC_RESET` immediately.
- beq with `imm`=-1 at `brPc`=0 → `branchTarget`=0x0000_0000 (4 - 4). beq with `imm` chosen so the sum exceeds 2^32 → the result wraps modulo 2^32.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: owns the program counter, resolves beq/bne/j/jr branches,
// drives the next-PC select mux and opens a flush window after a taken branch.
module branch_pc_unit #(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        brValid,
  input  logic [1:0]  brType,
  input  logic [31:0] brPc,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic [31:0] imm,
  input  logic [25:0] jAddr,
  input  logic [31:0] nextPc,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] branchTarget,
  output logic        selectBranch,
  output logic        flush,
  output logic [31:0] branchCount
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_J   = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   count_q, count_d;

  logic [DATA_W-1:0]   br_pc_plus4;
  logic [DATA_W-1:0]   target;
  logic                taken;
  logic                resolve;
  logic                sel_branch;

  // Branch target for the instruction currently in the resolve stage
  always_comb begin
    br_pc_plus4 = brPc + 32'd4;
    target      = br_pc_plus4;
    case (brType)
      BR_BEQ, BR_BNE: target = br_pc_plus4 + (imm << 2);
      BR_J:           target = {br_pc_plus4[31:28], jAddr, 2'b00};
      default:        target = {rsData[31:2], 2'b00};
    endcase
  end

  // Taken decision: conditional compares for beq/bne, jumps always taken
  always_comb begin
    taken = 1'b1;
    case (brType)
      BR_BEQ:  taken = (rsData == rtData);
      BR_BNE:  taken = (rsData != rtData);
      default: taken = 1'b1;
    endcase
  end

  // Mux select; gated by reset so the mux cannot pick a target while held in reset
  always_comb begin
    resolve    = brValid & ~stall & (state_q == ST_RUN);
    sel_branch = rst_n & resolve & taken;
  end

  // PC takes the mux result on every non-stalled edge
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      pc_d = nextPc;
    end
  end

  // RUN/FLUSH next-state, flush counter and taken-branch counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (sel_branch) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          count_d = count_q + 32'd1;
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= PC_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign pc           = pc_q;
  assign pcPlus4      = pc_q + 32'd4;
  assign branchTarget = target;
  assign selectBranch = sel_branch;
  assign flush        = (state_q == ST_FLUSH);
  assign branchCount  = count_q;

endmodule
